max_n_seq: RTL and testbench
============================

// Module: max_n_seq
// PURPOSE
//   Sequential N-operand extremum unit: generalises the three-operand max
//   controller to a run-time count of up to N_MAX operands, selectable
//   max/min and signed/unsigned compare. It also returns the winning index.
//   Operands arrive on a valid/ready stream, one per cycle; the result is
//   held with a level 'done' until the next run.
//   Sits beside the armish datapath as a hardware accelerator.
// PARAMETERS
//   WIDTH  16  operand/result width in bits (matches reg16_t)
//   N_MAX  8   maximum operands per run; CW = $clog2(N_MAX+1)
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-low reset
//   start        in   1      begin run; sampled in IDLE or DONE only
//   count        in   CW     operands in this run, sampled with start
//   mode_min     in   1      1 = minimum, 0 = maximum; sampled with start
//   mode_signed  in   1      1 = two's-complement compare; sampled with start
//   in_valid     in   1      operand valid
//   in_data      in   WIDTH  operand
//   in_ready     out  1      operand accepted when in_valid & in_ready
//   busy         out  1      high in RUN
//   done         out  1      high in DONE (level)
//   err          out  1      run rejected (count==0 or count>N_MAX); valid with done
//   result       out  WIDTH  extremum value; valid with done
//   result_idx   out  CW     0-based arrival index of result; valid with done
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE; in_ready, busy, done and err are 0.
//   result=0 and result_idx=0.
//   States: IDLE, RUN, DONE (2-bit encoding).
//   IDLE: in_ready=0. If start, latch count and both modes. Then:
//     - count==0 or count>N_MAX -> DONE, err=1, result=0, result_idx=0.
//     - otherwise -> RUN, beat counter k=0, err=0.
//   RUN: in_ready=1, busy=1. start is ignored. Each accepted beat:
//     - k==0: acc<=in_data, idx<=0 (unconditional load).
//     - k>0: replace acc/idx iff in_data is strictly better. Better means
//       greater for max, less for min, using signed or unsigned compare.
//       Ties keep the earlier index.
//     - k<=k+1. The beat with k==count-1 is accepted; next cycle -> DONE.
//     - in_valid low: state and k hold (bubbles allowed).
//   DONE: done=1, in_ready=0. result and result_idx are held stable.
//     start in DONE relatches inputs and applies the IDLE rules in the same
//     cycle, so a back-to-back run is possible. done drops on the following
//     cycle.
//   Latency: done rises on the first clk edge after the last accepted beat.
//     Minimum run = count+1 cycles after start.
//   Width rules: compare is full WIDTH, no truncation. CW is sized so that
//     count==N_MAX is representable; k never wraps within a legal run.
//   Reset mid-RUN: abort immediately. Partial acc is discarded; outputs go
//     to their reset values.
//   Inputs on in_data outside RUN are ignored; no operand is buffered.
// TESTING
//   count=3, max, unsigned; stream 1,2,3 -> done after 4 cycles,
//     result=3, idx=2, err=0.
//   Stream 2,1,3 then 3,1,2 (back-to-back start in DONE) -> result=3, idx=2;
//     then result=3, idx=0.
//   count=3, min, signed; stream 0x0005,0xFFFF,0x8000 -> result=0x8000,
//     idx=2. Same stream unsigned -> result=0x0005, idx=0.
//   count=4, max; stream 7,9,9,2 with in_valid low 2 cycles between beats
//     -> result=9, idx=1 (tie keeps first); done only after 4th beat.
//   start with count=0 -> DONE next cycle, err=1, result=0.
//     count=N_MAX+1 (=9) -> err=1.
//   count=8, reset pulsed low after 3 beats -> outputs 0 and IDLE at once.
//     A new run of 8 beats (max = 0xFFFF at beat 7) -> result=0xFFFF, idx=7.

Source files
------------

// File: rtl/max_n_seq.sv
// Sequential N-operand extremum unit (max/min, signed/unsigned) that also reports the winning index.
// Latency: one operand per cycle; done rises on the first clk edge after the last accepted beat (count+1 cycles minimum).
// Backpressure: in_ready is high only in RUN; bubbles on in_valid stall the run, and nothing is buffered outside RUN.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start             begin a run (honoured in IDLE or DONE only)
//   count             operands in this run, latched with start
//   mode_min          1 = minimum, 0 = maximum, latched with start
//   mode_signed       1 = two's-complement compare, latched with start
//   in_valid/in_data  operand stream; in_ready marks acceptance
//   busy / done       RUN / DONE state indicators (done is a level)
//   err               run rejected for an illegal count; valid with done
//   result            extremum value; valid with done
//   result_idx        0-based arrival index of result; valid with done
module max_n_seq #(
  parameter int WIDTH = 16,
  parameter int N_MAX = 8,
  localparam int CW   = $clog2(N_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CW-1:0]    count,
  input  logic             mode_min,
  input  logic             mode_signed,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    result_idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    k_q, k_d;
  logic             mode_min_q, mode_min_d;
  logic             mode_signed_q, mode_signed_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             err_q, err_d;

  logic             greater;
  logic             less;
  logic             better;

  // Strict comparisons only, so a tie never displaces the earlier index.
  always_comb begin
    greater = 1'b0;
    less    = 1'b0;
    if (mode_signed_q) begin
      greater = $signed(in_data) > $signed(acc_q);
      less    = $signed(in_data) < $signed(acc_q);
    end else begin
      greater = in_data > acc_q;
      less    = in_data < acc_q;
    end
    better = mode_min_q ? less : greater;
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    k_d           = k_q;
    mode_min_d    = mode_min_q;
    mode_signed_d = mode_signed_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    err_d         = err_q;

    case (state_q)
      // DONE shares the IDLE start rules so back-to-back runs need no idle cycle.
      S_IDLE, S_DONE: begin
        if (start) begin
          count_d       = count;
          mode_min_d    = mode_min;
          mode_signed_d = mode_signed;
          if ((count == '0) || (count > CW'(N_MAX))) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            acc_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = S_RUN;
            k_d     = '0;
            err_d   = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (in_valid) begin
          // First beat loads unconditionally; the accumulator holds stale data.
          if ((k_q == '0) || better) begin
            acc_d = in_data;
            idx_d = k_q;
          end
          k_d = k_q + CW'(1);
          if (k_q == (count_q - CW'(1))) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      k_q           <= '0;
      mode_min_q    <= 1'b0;
      mode_signed_q <= 1'b0;
      acc_q         <= '0;
      idx_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      k_q           <= k_d;
      mode_min_q    <= mode_min_d;
      mode_signed_q <= mode_signed_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      err_q         <= err_d;
    end
  end

  assign in_ready   = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign result     = acc_q;
  assign result_idx = idx_q;

endmodule

// File: tb/tb_max_n_seq.sv
module tb_max_n_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  count;
  logic        mode_min;
  logic        mode_signed;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] result;
  logic [3:0]  result_idx;

  int n_chk;
  int n_pass;

  logic [15:0] vec [8];

  max_n_seq #(.WIDTH(16), .N_MAX(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .count       (count),
    .mode_min    (mode_min),
    .mode_signed (mode_signed),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .result      (result),
    .result_idx  (result_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then stream n beats from vec with 'gap' idle cycles between beats.
  task automatic run(input int cnt, input logic mn, input logic sg, input int n, input int gap);
    start       = 1'b1;
    count       = 4'(cnt);
    mode_min    = mn;
    mode_signed = sg;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("done_drops", {31'd0, done}, 32'd0);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      tick();
      in_valid = 1'b0;
      in_data  = 16'hDEAD;
      if (i < n - 1) begin
        chk("no_early_done", {31'd0, done}, 32'd0);
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("done_in_gap", {31'd0, done}, 32'd0);
        end
      end
    end
    chk("done_latency", {31'd0, done}, 32'd1);
    chk("ready_low_done", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic chk_res(input string tag, input logic [15:0] r, input logic [3:0] idx, input logic e);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, r});
    chk({tag, "_idx"}, {28'd0, result_idx}, {28'd0, idx});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    reset       = 1'b0;
    start       = 1'b0;
    count       = 4'd0;
    mode_min    = 1'b0;
    mode_signed = 1'b0;
    in_valid    = 1'b0;
    in_data     = 16'd0;
    for (int i = 0; i < 8; i++) vec[i] = 16'd0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk_res("rst", 16'd0, 4'd0, 1'b0);
    reset = 1'b1;
    tick();

    // Operands offered in IDLE must be ignored.
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    in_valid = 1'b0;
    chk("idle_ignore_result", {16'd0, result}, 32'd0);
    chk("idle_ready", {31'd0, in_ready}, 32'd0);

    // max unsigned 1,2,3
    vec[0] = 16'd1; vec[1] = 16'd2; vec[2] = 16'd3;
    run(3, 1'b0, 1'b0, 3, 0);
    chk_res("max123", 16'd3, 4'd2, 1'b0);

    // 2,1,3 then back-to-back 3,1,2
    vec[0] = 16'd2; vec[1] = 16'd1; vec[2] = 16'd3;
    run(3, 1'b0, 1'b0, 3, 0);
    chk_res("max213", 16'd3, 4'd2, 1'b0);
    vec[0] = 16'd3; vec[1] = 16'd1; vec[2] = 16'd2;
    run(3, 1'b0, 1'b0, 3, 0);
    chk_res("max312", 16'd3, 4'd0, 1'b0);

    // min signed vs unsigned
    vec[0] = 16'h0005; vec[1] = 16'hFFFF; vec[2] = 16'h8000;
    run(3, 1'b1, 1'b1, 3, 0);
    chk_res("min_signed", 16'h8000, 4'd2, 1'b0);
    run(3, 1'b1, 1'b0, 3, 0);
    chk_res("min_unsigned", 16'h0005, 4'd0, 1'b0);

    // max signed: 0xFFFF is -1, so 0x0005 wins
    run(3, 1'b0, 1'b1, 3, 0);
    chk_res("max_signed", 16'h0005, 4'd0, 1'b0);

    // tie keeps first, with bubbles
    vec[0] = 16'd7; vec[1] = 16'd9; vec[2] = 16'd9; vec[3] = 16'd2;
    run(4, 1'b0, 1'b0, 4, 2);
    chk_res("tie_gap", 16'd9, 4'd1, 1'b0);

    // count==0 -> err
    start = 1'b1; count = 4'd0; mode_min = 1'b0; mode_signed = 1'b0;
    tick();
    start = 1'b0;
    chk("cnt0_done", {31'd0, done}, 32'd1);
    chk("cnt0_busy", {31'd0, busy}, 32'd0);
    chk_res("cnt0", 16'd0, 4'd0, 1'b1);

    // count==1 legal run clears err
    vec[0] = 16'hABCD;
    run(1, 1'b0, 1'b0, 1, 0);
    chk_res("cnt1", 16'hABCD, 4'd0, 1'b0);

    // count==9 -> err
    start = 1'b1; count = 4'd9;
    tick();
    start = 1'b0;
    chk("cnt9_done", {31'd0, done}, 32'd1);
    chk_res("cnt9", 16'd0, 4'd0, 1'b1);

    // count==8, reset after 3 beats
    start = 1'b1; count = 4'd8; mode_min = 1'b0; mode_signed = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0010 * 16'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    chk("midrun_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #2;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd0);
    chk_res("abort", 16'd0, 4'd0, 1'b0);
    reset = 1'b1;
    tick();
    chk("post_reset_idle", {31'd0, busy}, 32'd0);

    // full 8-beat run, max at last beat
    for (int i = 0; i < 7; i++) vec[i] = 16'(i + 1);
    vec[7] = 16'hFFFF;
    run(8, 1'b0, 1'b0, 8, 0);
    chk_res("full8", 16'hFFFF, 4'd7, 1'b0);

    // result held stable in DONE
    tick();
    tick();
    chk("hold_done", {31'd0, done}, 32'd1);
    chk_res("hold", 16'hFFFF, 4'd7, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
